ahb_lite_manager: RTL and testbench

- AHB-Lite manager (initiator): the bus-driving counterpart to the accelerator's AHB subordinate.
- Used by the testbench/CPU-model side and by the future on-chip DMA sequencer to issue single transfers to the accelerator register/SRAM space.
- Converts a simple valid/ready request stream into pipelined AHB-Lite SINGLE transfers and returns one response per request, in order, including error status.

---
 rtl/ahb_lite_manager.sv | 166 ++++++++++++++++
 tb/tb_ahb_lite_manager.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns a valid/ready request stream into pipelined SINGLE
// transfers and returns one in-order response per request, with error status.
module ahb_lite_manager #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  localparam logic [1:0] HTRANS_IDLE    = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;

  logic              aph_valid_q, aph_valid_d;
  logic [ADDR_W-1:0] aph_addr_q,  aph_addr_d;
  logic [1:0]        aph_size_q,  aph_size_d;
  logic              aph_write_q, aph_write_d;
  logic [DATA_W-1:0] aph_wdata_q, aph_wdata_d;
  logic              dph_valid_q, dph_valid_d;
  logic              dph_write_q, dph_write_d;
  logic [DATA_W-1:0] dph_wdata_q, dph_wdata_d;
  logic              err_hold_q,  err_hold_d;
  logic              cancel_pend_q, cancel_pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              accept;

  assign req_ready = !err_hold_q && (!aph_valid_q || hready);
  assign accept    = req_valid && req_ready;

  assign hsel      = aph_valid_q;
  assign htrans    = aph_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = aph_addr_q;
  assign hsize     = {1'b0, aph_size_q};
  assign hwrite    = aph_write_q;
  assign hburst    = 3'b000;
  assign hwdata    = dph_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    aph_valid_d   = aph_valid_q;
    aph_addr_d    = aph_addr_q;
    aph_size_d    = aph_size_q;
    aph_write_d   = aph_write_q;
    aph_wdata_d   = aph_wdata_q;
    dph_valid_d   = dph_valid_q;
    dph_write_d   = dph_write_q;
    dph_wdata_d   = dph_wdata_q;
    err_hold_d    = err_hold_q;
    cancel_pend_d = cancel_pend_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = '0;

    if (hready) begin
      if (dph_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = hresp;
        rsp_rdata_d = (hresp || dph_write_q) ? '0 : hrdata;
        if (err_hold_q && !cancel_pend_q) begin
          err_hold_d = 1'b0;
        end else begin
          err_hold_d = err_hold_q;
        end
      end else if (cancel_pend_q) begin
        // Bus is idle behind the failed transfer: report the cancelled request.
        rsp_valid_d   = 1'b1;
        rsp_err_d     = 1'b1;
        cancel_pend_d = 1'b0;
        err_hold_d    = 1'b0;
      end else begin
        rsp_valid_d = 1'b0;
      end
      dph_valid_d = aph_valid_q;
      dph_write_d = aph_write_q;
      if (aph_valid_q) begin
        dph_wdata_d = aph_wdata_q;
      end else begin
        dph_wdata_d = dph_wdata_q;
      end
      aph_valid_d = accept;
      if (accept) begin
        aph_addr_d  = req_addr;
        aph_size_d  = req_size;
        aph_write_d = req_write;
        aph_wdata_d = req_wdata;
      end else begin
        aph_addr_d  = aph_addr_q;
      end
    end else if (hresp && dph_valid_q && !err_hold_q) begin
      // First error cycle: withdraw whatever sits in (or enters) the address phase.
      err_hold_d = 1'b1;
      if (aph_valid_q || accept) begin
        cancel_pend_d = 1'b1;
        aph_valid_d   = 1'b0;
      end else begin
        cancel_pend_d = cancel_pend_q;
      end
    end else begin
      if (accept) begin
        aph_valid_d = 1'b1;
        aph_addr_d  = req_addr;
        aph_size_d  = req_size;
        aph_write_d = req_write;
        aph_wdata_d = req_wdata;
      end else begin
        aph_valid_d = aph_valid_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      aph_valid_q   <= 1'b0;
      aph_addr_q    <= '0;
      aph_size_q    <= 2'b00;
      aph_write_q   <= 1'b0;
      aph_wdata_q   <= '0;
      dph_valid_q   <= 1'b0;
      dph_write_q   <= 1'b0;
      dph_wdata_q   <= '0;
      err_hold_q    <= 1'b0;
      cancel_pend_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      aph_valid_q   <= aph_valid_d;
      aph_addr_q    <= aph_addr_d;
      aph_size_q    <= aph_size_d;
      aph_write_q   <= aph_write_d;
      aph_wdata_q   <= aph_wdata_d;
      dph_valid_q   <= dph_valid_d;
      dph_write_q   <= dph_write_d;
      dph_wdata_q   <= dph_wdata_d;
      err_hold_q    <= err_hold_d;
      cancel_pend_q <= cancel_pend_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed testbench for ahb_lite_manager: hand-computed expectations checked
// with immediate assertions while the bench plays the subordinate.
module tb_ahb_lite_manager;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        hsel, hwrite, hready, hresp;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [63:0] hwdata, hrdata;

  int vectors    = 0;
  int miscompares = 0;

  ahb_lite_manager #(.ADDR_W(8), .DATA_W(64)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [7:0] a, input logic [63:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = 2'd3; req_wdata = d;
  endtask

  logic [63:0] wd [3];

  initial begin
    n_rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
    req_size = 2'd0; req_wdata = 64'd0; hready = 1'b1; hresp = 1'b0; hrdata = 64'd0;
    wd[0] = 64'h1111_0000_0000_0001;
    wd[1] = 64'h2222_0000_0000_0002;
    wd[2] = 64'h3333_0000_0000_0003;
    #3;
    chk("rst_htrans", {62'd0, htrans}, 64'd0);
    chk("rst_hsel", {63'd0, hsel}, 64'd0);
    chk("rst_haddr", {56'd0, haddr}, 64'd0);
    chk("rst_hsize", {61'd0, hsize}, 64'd0);
    chk("rst_hwdata", hwdata, 64'd0);
    chk("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
    step(); step();
    n_rst = 1'b1;
    step();

    // Zero-wait read
    req(1'b0, 8'h10, 64'd0);
    #1 chk("rd_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0; hrdata = 64'hDEAD_BEEF_0123_4567;
    chk("rd_htrans", {62'd0, htrans}, 64'd2);
    chk("rd_hsel", {63'd0, hsel}, 64'd1);
    chk("rd_haddr", {56'd0, haddr}, 64'h10);
    chk("rd_hsize", {61'd0, hsize}, 64'd3);
    chk("rd_hwrite", {63'd0, hwrite}, 64'd0);
    step();
    chk("rd_dph_idle", {62'd0, htrans}, 64'd0);
    chk("rd_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
    step();
    chk("rd_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
    chk("rd_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    step();
    chk("rd_rsp_pulse", {63'd0, rsp_valid}, 64'd0);

    // Back-to-back writes
    for (int c = 0; c < 7; c++) begin
      if (c < 3) req(1'b1, 8'(c * 8), wd[c]);
      else req_valid = 1'b0;
      if (c >= 1 && c <= 3) begin
        chk("bb_htrans", {62'd0, htrans}, 64'd2);
        chk("bb_haddr", {56'd0, haddr}, 64'((c - 1) * 8));
      end
      if (c >= 2 && c <= 4) chk("bb_hwdata", hwdata, wd[c-2]);
      if (c == 4) chk("bb_idle", {62'd0, htrans}, 64'd0);
      if (c >= 3 && c <= 5) chk("bb_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
      if (c >= 3 && c <= 5) chk("bb_rdata", rsp_rdata, 64'd0);
      if (c == 6) chk("bb_rsp_end", {63'd0, rsp_valid}, 64'd0);
      step();
    end

    // Write then read with a 2-cycle stall in the write data phase
    req(1'b1, 8'h20, 64'hAAAA_5555_AAAA_5555);
    step();
    req(1'b0, 8'h28, 64'd0);
    step();
    req_valid = 1'b0; hready = 1'b0;
    #1 chk("st_ready", {63'd0, req_ready}, 64'd0);
    step();
    chk("st_haddr", {56'd0, haddr}, 64'h28);
    chk("st_htrans", {62'd0, htrans}, 64'd2);
    chk("st_hwdata", hwdata, 64'hAAAA_5555_AAAA_5555);
    chk("st_no_rsp", {63'd0, rsp_valid}, 64'd0);
    step();
    chk("st_haddr2", {56'd0, haddr}, 64'h28);
    chk("st_hwdata2", hwdata, 64'hAAAA_5555_AAAA_5555);
    chk("st_no_rsp2", {63'd0, rsp_valid}, 64'd0);
    hready = 1'b1; hrdata = 64'h0BAD_CAFE_0000_0028;
    step();
    chk("st_wr_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
    chk("st_wr_rdata", rsp_rdata, 64'd0);
    hrdata = 64'h0000_0000_CAFE_F00D;
    step();
    chk("st_rd_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
    chk("st_rd_rdata", rsp_rdata, 64'h0000_0000_CAFE_F00D);
    step();

    // Error on a write with a read in the address phase
    req(1'b1, 8'h30, 64'h3030);
    step();
    req(1'b0, 8'h38, 64'd0);
    step();
    req_valid = 1'b0; hresp = 1'b1; hready = 1'b0;
    #1 chk("er_ready1", {63'd0, req_ready}, 64'd0);
    step();
    hready = 1'b1;
    #1 chk("er_htrans", {62'd0, htrans}, 64'd0);
    chk("er_hsel", {63'd0, hsel}, 64'd0);
    chk("er_no_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("er_ready2", {63'd0, req_ready}, 64'd0);
    step();
    hresp = 1'b0;
    req(1'b0, 8'h40, 64'd0);
    #1 chk("er_rsp1", {62'd0, rsp_valid, rsp_err}, 64'd3);
    chk("er_rdata1", rsp_rdata, 64'd0);
    chk("er_ready3", {63'd0, req_ready}, 64'd0);
    step();
    chk("er_rsp2", {62'd0, rsp_valid, rsp_err}, 64'd3);
    chk("er_not_taken", {62'd0, htrans}, 64'd0);
    chk("er_ready4", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0; hrdata = 64'h4040_4040_4040_4040;
    chk("er_new_htrans", {62'd0, htrans}, 64'd2);
    chk("er_new_haddr", {56'd0, haddr}, 64'h40);
    chk("er_rsp_end", {63'd0, rsp_valid}, 64'd0);
    step(); step();
    chk("er_new_rsp", {62'd0, rsp_valid, rsp_err}, 64'd2);
    chk("er_new_rdata", rsp_rdata, 64'h4040_4040_4040_4040);
    step();

    // Reset while a read is in the data phase
    req(1'b0, 8'h50, 64'd0);
    step();
    req_valid = 1'b0;
    step();
    n_rst = 1'b0;
    #1 chk("mr_htrans", {62'd0, htrans}, 64'd0);
    chk("mr_haddr", {56'd0, haddr}, 64'd0);
    chk("mr_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
    step();
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mr_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end

    // Idle bus
    for (int c = 0; c < 10; c++) begin
      chk("idle_htrans", {62'd0, htrans}, 64'd0);
      chk("idle_hsel", {63'd0, hsel}, 64'd0);
      chk("idle_hburst", {61'd0, hburst}, 64'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
